aes_cipher_core: RTL



---
 rtl/aes_cipher_core.sv | 133 +++++++++++++
 1 files changed

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryption core. It runs one round per clock over a 128-bit state register.
// Round keys are pulled from external key expansion in ascending order, using rkey_en and round_num.
module aes_cipher_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plain_text,
  input  logic [127:0] round_key,
  output logic         ready,
  output logic         rkey_en,
  output logic [3:0]   round_num,
  output logic [127:0] cipher_text,
  output logic         cipher_valid
);
  typedef enum logic {IDLE, ROUND} state_t;

  state_t       state, state_nx;
  logic [3:0]   rcnt, rcnt_nx;
  logic [127:0] state_reg, st_nx, ct_nx;
  logic         cv_nx;
  logic [127:0] mix_state, fin_state;
  logic [7:0]   st_b [16];
  logic [7:0]   sr_b [16];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254 via an addition chain) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x3, x7, x15, x31, x63, x127, inv;
    x3   = gmul(gmul(x, x), x);
    x7   = gmul(gmul(x3, x3), x);
    x15  = gmul(gmul(x7, x7), x);
    x31  = gmul(gmul(x15, x15), x);
    x63  = gmul(gmul(x31, x31), x);
    x127 = gmul(gmul(x63, x63), x);
    inv  = gmul(x127, x127);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // ShiftRows is pure wiring. It commutes with the bytewise SubBytes, so it is applied first.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign st_b[4*c+r] = state_reg[127-8*(4*c+r) -: 8];
      assign sr_b[4*c+r] = st_b[4*((c+r)%4)+r];
    end

    logic [7:0]  a0, a1, a2, a3;
    logic [31:0] rk_col;
    assign a0     = sbox(sr_b[4*c]);
    assign a1     = sbox(sr_b[4*c+1]);
    assign a2     = sbox(sr_b[4*c+2]);
    assign a3     = sbox(sr_b[4*c+3]);
    assign rk_col = round_key[127-32*c -: 32];

    assign mix_state[127-32*c -: 32] = rk_col ^ {
      xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
      xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    assign fin_state[127-32*c -: 32] = rk_col ^ {a0, a1, a2, a3};
  end

  always_comb begin
    state_nx  = state;
    rcnt_nx   = rcnt;
    st_nx     = state_reg;
    ct_nx     = cipher_text;
    cv_nx     = 1'b0;
    ready     = 1'b0;
    rkey_en   = 1'b0;
    round_num = 4'd0;
    case (state)
      IDLE: begin
        ready   = 1'b1;
        rkey_en = start;
        if (start) begin
          st_nx    = plain_text ^ round_key;
          rcnt_nx  = 4'd1;
          state_nx = ROUND;
        end
      end
      ROUND: begin
        round_num = rcnt;
        rkey_en   = 1'b1;
        if (rcnt >= 4'd1 && rcnt <= 4'd9) begin
          st_nx   = mix_state;
          rcnt_nx = rcnt + 4'd1;
        end else if (rcnt == 4'd10) begin
          ct_nx    = fin_state;
          cv_nx    = 1'b1;
          rcnt_nx  = 4'd0;
          state_nx = IDLE;
        end else begin
          // Unreachable counts: abandon the block quietly.
          rcnt_nx  = 4'd0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rcnt         <= 4'd0;
      state_reg    <= '0;
      cipher_text  <= '0;
      cipher_valid <= 1'b0;
    end else begin
      state        <= state_nx;
      rcnt         <= rcnt_nx;
      state_reg    <= st_nx;
      cipher_text  <= ct_nx;
      cipher_valid <= cv_nx;
    end
  end
endmodule
